// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/DIVU): one quotient bit per clock, sign fix-up
// in a final cycle, results returned through a start/busy/done handshake.

module CarryLookaheadAdder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s    = p ^ c[3:0];
  assign cout = c[4];
endmodule

module PartialFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic p,
  output logic g
);
  assign p = a ^ b;
  assign g = a & b;
  assign s = p ^ cin;
endmodule

module cla_chain #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int N = WIDTH / 4;
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_blk
    CarryLookaheadAdder_4bit u_cla (
      .a(a[4*i +: 4]), .b(b[4*i +: 4]), .cin(c[i]), .s(sum[4*i +: 4]), .cout(c[i+1])
    );
  end
  assign cout = c[N];
endmodule

module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t           state;
  logic             sgn, dvd_neg, dvs_neg;
  logic [WIDTH-1:0] quo, dvs;
  logic [WIDTH:0]   rem;
  logic [5:0]       cnt;

  // trial subtraction: rem_sh + ~dvs + 1, top bit through a partial full adder
  logic [WIDTH:0]   rem_sh, trial;
  logic             lo_co, pfa_s, pfa_p, pfa_g, trial_co;
  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};

  cla_chain #(.WIDTH(WIDTH)) u_trial (
    .a(rem_sh[WIDTH-1:0]), .b(~dvs), .cin(1'b1), .sum(trial[WIDTH-1:0]), .cout(lo_co)
  );
  PartialFullAdder u_top (
    .a(rem_sh[WIDTH]), .b(1'b1), .cin(lo_co), .s(pfa_s), .p(pfa_p), .g(pfa_g)
  );
  assign trial[WIDTH] = pfa_s;
  assign trial_co     = pfa_g | (pfa_p & lo_co);

  // negation chains shared between operand magnitudes (at Start) and sign fix-up (in FIX)
  logic [WIDTH-1:0] na_in, nb_in, neg_a, neg_b;
  logic             na_co, nb_co;
  assign na_in = (state == FIX) ? quo : Dividend;
  assign nb_in = (state == FIX) ? rem[WIDTH-1:0] : Divisor;

  cla_chain #(.WIDTH(WIDTH)) u_neg_a (
    .a(~na_in), .b('0), .cin(1'b1), .sum(neg_a), .cout(na_co)
  );
  cla_chain #(.WIDTH(WIDTH)) u_neg_b (
    .a(~nb_in), .b('0), .cin(1'b1), .sum(neg_b), .cout(nb_co)
  );

  logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fix, r_fix;
  assign dvd_mag = (Signed && Dividend[WIDTH-1]) ? neg_a : Dividend;
  assign dvs_mag = (Signed && Divisor[WIDTH-1])  ? neg_b : Divisor;
  assign q_fix   = (sgn && (dvd_neg ^ dvs_neg)) ? neg_a : quo;
  assign r_fix   = (sgn && dvd_neg) ? neg_b : rem[WIDTH-1:0];

  // rem[WIDTH] is always 0 after a restoring step; carry-outs of the negators are don't-care
  logic unused;
  assign unused = ^{rem[WIDTH], na_co, nb_co};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      sgn       <= 1'b0;
      dvd_neg   <= 1'b0;
      dvs_neg   <= 1'b0;
      quo       <= '0;
      dvs       <= '0;
      rem       <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivZero   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            sgn     <= Signed;
            dvd_neg <= Signed & Dividend[WIDTH-1];
            dvs_neg <= Signed & Divisor[WIDTH-1];
            quo     <= dvd_mag;
            dvs     <= dvs_mag;
            rem     <= '0;
            cnt     <= '0;
            if (Divisor == '0) begin
              state     <= DONE;
              Done      <= 1'b1;
              Quotient  <= '1;
              Remainder <= Dividend;
              DivZero   <= 1'b1;
            end else begin
              state <= RUN;
              Busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          quo <= {quo[WIDTH-2:0], trial_co};
          rem <= trial_co ? trial : rem_sh;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          Quotient  <= q_fix;
          Remainder <= r_fix;
          DivZero   <= 1'b0;
          Busy      <= 1'b0;
          Done      <= 1'b1;
          state     <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: cycle-level reference model compared every cycle,
// plus directed operations with hand-computed results and latencies.

module tb_seq_divider;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         Start, Signed;
  logic [W-1:0] Dividend, Divisor;
  logic [W-1:0] Quotient, Remainder;
  logic         Busy, Done, DivZero;

  int n_cmp  = 0;
  int n_fail = 0;

  seq_divider #(.WIDTH(W)) dut (
    .CLK(CLK), .RST_N(RST_N), .Start(Start), .Signed(Signed),
    .Dividend(Dividend), .Divisor(Divisor), .Quotient(Quotient),
    .Remainder(Remainder), .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 CLK = ~CLK;

  // reference division with plain arithmetic: returns {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    longint la, lb, lq, lr;
    logic [63:0] tq, tr;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    la = sg ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
    lb = sg ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
    lq = la / lb;
    lr = la % lb;
    tq = lq;
    tr = lr;
    return {tr[31:0], tq[31:0]};
  endfunction

  // cycle model: accepted op finishes W+1 edges later, divide-by-zero immediately
  int           m_cnt;
  logic         m_done, m_dz;
  logic [W-1:0] m_q, m_r;
  logic [63:0]  m_pend;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_cnt <= 0; m_done <= 1'b0; m_dz <= 1'b0; m_q <= '0; m_r <= '0; m_pend <= '0;
    end else if (m_cnt == 0) begin
      m_done <= 1'b0;
      if (Start) begin
        if (Divisor == 0) begin
          m_done <= 1'b1; m_q <= '1; m_r <= Dividend; m_dz <= 1'b1;
        end else begin
          m_cnt  <= W + 1;
          m_pend <= ref_div(Signed, Dividend, Divisor);
        end
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1; m_q <= m_pend[31:0]; m_r <= m_pend[63:32]; m_dz <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    n_cmp++;
    if (Busy !== (m_cnt != 0) || Done !== m_done || DivZero !== m_dz ||
        Quotient !== m_q || Remainder !== m_r) begin
      n_fail++;
      $display("FAIL model t=%0t: busy/done/dz/q/r got %b %b %b %h %h want %b %b %b %h %h",
               $time, Busy, Done, DivZero, Quotient, Remainder,
               m_cnt != 0, m_done, m_dz, m_q, m_r);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // caller is positioned just after a negedge; Start lands in the current cycle
  task automatic run_op(input string nm, input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic edz,
                        input int elat, input logic scramble);
    int lat;
    #1;
    Signed = sg; Dividend = a; Divisor = b; Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    if (scramble) begin
      Dividend = 32'h0BAD_F00D; Divisor = 32'h3; Signed = 1'b1;
    end
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge CLK);
      if (Done) begin lat = k; break; end
    end
    chk({nm, " latency"}, lat, elat);
    chk({nm, " quotient"}, Quotient, eq);
    chk({nm, " remainder"}, Remainder, er);
    chk({nm, " divzero"}, {31'b0, DivZero}, {31'b0, edz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, d1, d2;
    RST_N = 1'b1; Start = 1'b0; Signed = 1'b0; Dividend = '0; Divisor = '0;
    #1 RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset quotient", Quotient, 32'h0);
    chk("reset remainder", Remainder, 32'h0);
    chk("reset busy/done/dz", {29'b0, Busy, Done, DivZero}, 32'h0);
    #1 RST_N = 1'b1;
    @(negedge CLK);

    run_op("udiv 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b0);
    run_op("sdiv -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);
    run_op("sdiv 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 1'b0, 34, 1'b0);
    run_op("div by zero", 1'b0, 32'h1234, 32'h0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1, 1'b0);
    run_op("9/3 after dz", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34, 1'b0);
    run_op("sdiv overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 1'b0, 34, 1'b0);
    run_op("udiv max/1", 1'b0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b0, 34, 1'b0);
    run_op("udiv 5/9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 34, 1'b0);
    run_op("operands change", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 1'b1);

    // Start held high across two full operations
    #1;
    Signed = 1'b0; Dividend = 32'd100; Divisor = 32'd7; Start = 1'b1;
    @(posedge CLK);
    nd = 0; d1 = 0; d2 = 0;
    for (int k = 1; k <= 75; k++) begin
      @(negedge CLK);
      if (Done) begin
        nd++;
        if (nd == 1) d1 = k; else if (nd == 2) d2 = k;
        chk("held start quotient", Quotient, 32'd14);
        chk("held start remainder", Remainder, 32'd2);
      end
      if (k == 20) begin #1 Dividend = 32'd77; Divisor = 32'd5; end
      if (k == 30) begin #1 Dividend = 32'd100; Divisor = 32'd7; end
      if (k == 40) begin #1 Start = 1'b0; Dividend = 32'd1; Divisor = 32'd1; end
    end
    chk("held start done count", nd, 2);
    chk("held start first done", d1, 34);
    chk("held start second done", d2, 68);

    // divide-by-zero, then reset in the middle of a back-to-back operation
    run_op("dz again", 1'b1, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, 1, 1'b0);
    #1;
    Signed = 1'b0; Dividend = 32'd100; Divisor = 32'd7; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    repeat (10) @(negedge CLK);
    chk("busy before reset", {31'b0, Busy}, 32'h1);
    #1 RST_N = 1'b0;
    #1;
    chk("mid-run reset quotient", Quotient, 32'h0);
    chk("mid-run reset remainder", Remainder, 32'h0);
    chk("mid-run reset busy/done/dz", {29'b0, Busy, Done, DivZero}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("no done in reset", {31'b0, Done}, 32'h0);
    end
    #1 RST_N = 1'b1;
    @(negedge CLK);
    run_op("50/5 after reset", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34, 1'b0);

    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
